// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory handshake FSM with
// wait-state timeout, alignment check, and the MEM/WB register.
//
// Ports:
//   clk, rst_n            - single rising-edge clock, async active-low reset
//   result, readData2,    - EX-side op: address/ALU result, store data,
//   rd_EX, *_EX, valid_EX   destination register and control bits
//   memReq/memWe/memAddr/ - data memory request; memAck completes it,
//   memWdata/memRdata/      memRdata returns load data on the ack cycle
//   memAck
//   result_EXMEM, rd_EXMEM, regWrite_EXMEM - EX/MEM contents for forwarding
//   rd_MEMWB, regWrite_MEMWB, valueToWB    - MEM/WB contents for writeback
//   stall                 - freeze upstream while waiting for memAck
//   alignErr, timeout     - one-cycle status pulses
module mem_stage #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] result,
    input  logic [31:0] readData2,
    input  logic [4:0]  rd_EX,
    input  logic        regWrite_EX,
    input  logic        memRead_EX,
    input  logic        memWrite_EX,
    input  logic        memToReg_EX,
    input  logic        valid_EX,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    input  logic        memAck,
    output logic [31:0] result_EXMEM,
    output logic [4:0]  rd_EXMEM,
    output logic        regWrite_EXMEM,
    output logic [4:0]  rd_MEMWB,
    output logic        regWrite_MEMWB,
    output logic [31:0] valueToWB,
    output logic        stall,
    output logic        alignErr,
    output logic        timeout
);

    localparam int unsigned CW_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CW     = (CW_RAW > 8) ? CW_RAW : 8;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    // EX/MEM register
    logic [31:0] result_ex_q, result_ex_d;
    logic [31:0] wdata_ex_q, wdata_ex_d;
    logic [4:0]  rd_ex_q, rd_ex_d;
    logic        regWrite_ex_q, regWrite_ex_d;
    logic        memRead_ex_q, memRead_ex_d;
    logic        memWrite_ex_q, memWrite_ex_d;
    logic        memToReg_ex_q, memToReg_ex_d;
    logic        valid_ex_q, valid_ex_d;

    // MEM/WB register
    logic [4:0]  rd_wb_q, rd_wb_d;
    logic        regWrite_wb_q, regWrite_wb_d;
    logic [31:0] value_wb_q, value_wb_d;

    logic load_ex;
    logic new_mem;
    logic ack_ok;
    logic mem_op_q;
    logic misalign;
    logic op_done;

    always_comb begin
        stall   = (state_q == ACCESS) && !memAck;
        ack_ok  = (state_q == ACCESS) && memAck;
        load_ex = !stall;

        // An aligned, valid memory op entering EX/MEM starts an access.
        new_mem = load_ex && valid_EX
                  && (memRead_EX || memWrite_EX)
                  && (result[1:0] == 2'b00);

        mem_op_q = valid_ex_q && (memRead_ex_q || memWrite_ex_q);
        misalign = mem_op_q && (result_ex_q[1:0] != 2'b00);

        // Aligned memory ops only ever sit in EX/MEM during ACCESS/DONE,
        // so in IDLE the held op is either non-memory or misaligned.
        op_done = ack_ok || ((state_q == IDLE) && !mem_op_q);
    end

    // EX/MEM next-state
    always_comb begin
        result_ex_d   = result_ex_q;
        wdata_ex_d    = wdata_ex_q;
        rd_ex_d       = rd_ex_q;
        regWrite_ex_d = regWrite_ex_q;
        memRead_ex_d  = memRead_ex_q;
        memWrite_ex_d = memWrite_ex_q;
        memToReg_ex_d = memToReg_ex_q;
        valid_ex_d    = valid_ex_q;
        if (load_ex) begin
            result_ex_d   = result;
            wdata_ex_d    = readData2;
            rd_ex_d       = rd_EX;
            // Writes to x0, bubbles and stores never reach the regfile.
            regWrite_ex_d = regWrite_EX && valid_EX
                            && (rd_EX != 5'd0) && !memWrite_EX;
            memRead_ex_d  = memRead_EX && valid_EX;
            memWrite_ex_d = memWrite_EX && valid_EX;
            memToReg_ex_d = memToReg_EX;
            valid_ex_d    = valid_EX;
        end
    end

    // Access FSM and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 1'b1;
        unique case (state_q)
            IDLE, DONE: begin
                if (new_mem) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (memAck) begin
                    if (new_mem) begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_inc >= TO_LIM) begin
                    state_d = DONE;
                    cnt_d   = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // MEM/WB next-state: loads every edge, bubble unless the op completed.
    always_comb begin
        rd_wb_d       = rd_ex_q;
        regWrite_wb_d = op_done && regWrite_ex_q && !memWrite_ex_q;
        if (ack_ok && memRead_ex_q && memToReg_ex_q) begin
            value_wb_d = memRdata;
        end else begin
            value_wb_d = result_ex_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            result_ex_q   <= '0;
            wdata_ex_q    <= '0;
            rd_ex_q       <= '0;
            regWrite_ex_q <= 1'b0;
            memRead_ex_q  <= 1'b0;
            memWrite_ex_q <= 1'b0;
            memToReg_ex_q <= 1'b0;
            valid_ex_q    <= 1'b0;
            rd_wb_q       <= '0;
            regWrite_wb_q <= 1'b0;
            value_wb_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            result_ex_q   <= result_ex_d;
            wdata_ex_q    <= wdata_ex_d;
            rd_ex_q       <= rd_ex_d;
            regWrite_ex_q <= regWrite_ex_d;
            memRead_ex_q  <= memRead_ex_d;
            memWrite_ex_q <= memWrite_ex_d;
            memToReg_ex_q <= memToReg_ex_d;
            valid_ex_q    <= valid_ex_d;
            rd_wb_q       <= rd_wb_d;
            regWrite_wb_q <= regWrite_wb_d;
            value_wb_q    <= value_wb_d;
        end
    end

    assign memReq         = (state_q == ACCESS);
    assign memWe          = memWrite_ex_q;
    assign memAddr        = {result_ex_q[31:2], 2'b00};
    assign memWdata       = wdata_ex_q;
    assign result_EXMEM   = result_ex_q;
    assign rd_EXMEM       = rd_ex_q;
    assign regWrite_EXMEM = regWrite_ex_q;
    assign rd_MEMWB       = rd_wb_q;
    assign regWrite_MEMWB = regWrite_wb_q;
    assign valueToWB      = value_wb_q;
    assign alignErr       = misalign;
    assign timeout        = (state_q == DONE);

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus random op stream
// checked against a transaction-level scoreboard.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] result, readData2, memRdata;
    logic [4:0]  rd_EX;
    logic        regWrite_EX, memRead_EX, memWrite_EX, memToReg_EX, valid_EX;
    logic        memAck;
    logic        memReq, memWe;
    logic [31:0] memAddr, memWdata;
    logic [31:0] result_EXMEM, valueToWB;
    logic [4:0]  rd_EXMEM, rd_MEMWB;
    logic        regWrite_EXMEM, regWrite_MEMWB;
    logic        stall, alignErr, timeout;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .result(result), .readData2(readData2), .rd_EX(rd_EX),
        .regWrite_EX(regWrite_EX), .memRead_EX(memRead_EX),
        .memWrite_EX(memWrite_EX), .memToReg_EX(memToReg_EX),
        .valid_EX(valid_EX),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memWdata(memWdata), .memRdata(memRdata), .memAck(memAck),
        .result_EXMEM(result_EXMEM), .rd_EXMEM(rd_EXMEM),
        .regWrite_EXMEM(regWrite_EXMEM), .rd_MEMWB(rd_MEMWB),
        .regWrite_MEMWB(regWrite_MEMWB), .valueToWB(valueToWB),
        .stall(stall), .alignErr(alignErr), .timeout(timeout)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] result, wdata, rdata;
        logic        regWrite, memRead, memWrite, memToReg;
        int          lat;
    } op_t;

    typedef struct {
        logic [31:0] addr, wdata, rdata;
        logic        we;
        int          lat;
    } acc_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } wb_t;

    op_t  pend_q[$];
    acc_t acc_q[$];
    wb_t  wb_q[$];
    op_t  cur_ex;
    acc_t cur_acc;
    logic have_cur;
    logic ex_loaded;
    int   wcnt;
    int   n_chk, n_pass, n_fail;
    int   n_req, n_stall, n_align, n_to, n_wb;
    int   exp_align, exp_to;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic op_t bubble();
        op_t o;
        o.valid    = 1'b0;
        o.rd       = 5'($urandom);
        o.result   = $urandom;
        o.wdata    = $urandom;
        o.rdata    = $urandom;
        o.regWrite = 1'b1;
        o.memRead  = 1'($urandom);
        o.memWrite = 1'($urandom);
        o.memToReg = 1'b1;
        o.lat      = 1;
        return o;
    endfunction

    function automatic op_t mk(input logic v, input logic [4:0] rd,
                               input logic [31:0] res, input logic [31:0] wd,
                               input logic rw, input logic mr, input logic mw,
                               input logic m2r, input int lat,
                               input logic [31:0] rdat);
        op_t o;
        o.valid = v; o.rd = rd; o.result = res; o.wdata = wd;
        o.regWrite = rw; o.memRead = mr; o.memWrite = mw;
        o.memToReg = m2r; o.lat = lat; o.rdata = rdat;
        return o;
    endfunction

    task automatic drive_ex(input op_t o);
        valid_EX    = o.valid;
        rd_EX       = o.rd;
        result      = o.result;
        readData2   = o.wdata;
        regWrite_EX = o.regWrite;
        memRead_EX  = o.memRead;
        memWrite_EX = o.memWrite;
        memToReg_EX = o.memToReg;
    endtask

    // Outcome of one op, decided from the architectural rules when the
    // stage accepts it: memory access (if any) and expected writeback.
    task automatic model_capture(input op_t o);
        acc_t a;
        wb_t  w;
        logic mem;
        if (!o.valid) return;
        mem = o.memRead || o.memWrite;
        if (mem && o.result[1:0] != 2'b00) begin
            exp_align++;
            return;
        end
        if (mem) begin
            a.addr = o.result; a.wdata = o.wdata; a.rdata = o.rdata;
            a.we = o.memWrite; a.lat = o.lat;
            acc_q.push_back(a);
            if (o.lat > TO) begin
                exp_to++;
                return;
            end
            if (o.memWrite) return;
        end
        if (o.regWrite && o.rd != 5'd0) begin
            w.rd  = o.rd;
            w.val = (o.memRead && o.memToReg) ? o.rdata : o.result;
            wb_q.push_back(w);
        end
    endtask

    task automatic cycle();
        wb_t w;
        @(posedge clk);
        #1;
        if (ex_loaded) begin
            model_capture(cur_ex);
            if (pend_q.size() != 0) cur_ex = pend_q.pop_front();
            else cur_ex = bubble();
            drive_ex(cur_ex);
        end
        if (memReq) begin
            if (!have_cur) begin
                chk("acc_pending", 32'(acc_q.size() != 0), 32'd1);
                if (acc_q.size() != 0) begin
                    cur_acc  = acc_q.pop_front();
                    have_cur = 1'b1;
                    wcnt     = 0;
                end
            end
            memAck   = have_cur && (wcnt + 1 == cur_acc.lat);
            memRdata = have_cur ? cur_acc.rdata : $urandom;
        end else begin
            memAck   = 1'($urandom);
            memRdata = $urandom;
        end
        @(negedge clk);
        if (memReq) n_req++;
        if (stall) n_stall++;
        if (alignErr) n_align++;
        if (timeout) n_to++;
        if (memReq && have_cur) begin
            if (memAck) begin
                chk("mem_addr", memAddr, cur_acc.addr);
                chk("mem_we", 32'(memWe), 32'(cur_acc.we));
                if (cur_acc.we) chk("mem_wdata", memWdata, cur_acc.wdata);
                have_cur = 1'b0;
            end else begin
                wcnt++;
                if (wcnt >= TO) have_cur = 1'b0;
            end
        end
        if (regWrite_MEMWB) begin
            n_wb++;
            chk("wb_pending", 32'(wb_q.size() != 0), 32'd1);
            if (wb_q.size() != 0) begin
                w = wb_q.pop_front();
                chk("wb_rd", 32'(rd_MEMWB), 32'(w.rd));
                chk("wb_val", valueToWB, w.val);
            end
        end
        ex_loaded = !stall;
    endtask

    task automatic clr();
        n_req = 0; n_stall = 0; n_align = 0; n_to = 0; n_wb = 0;
        exp_align = 0; exp_to = 0;
    endtask

    initial begin
        op_t o;
        int  budget;
        int  k;
        n_chk = 0; n_pass = 0; n_fail = 0;
        clr();
        have_cur  = 1'b0;
        ex_loaded = 1'b1;
        wcnt      = 0;
        cur_ex    = bubble();
        drive_ex(cur_ex);
        memAck    = 1'b0;
        memRdata  = '0;
        rst_n     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_memReq", 32'(memReq), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rw_memwb", 32'(regWrite_MEMWB), 32'd0);
        chk("rst_rd_memwb", 32'(rd_MEMWB), 32'd0);
        chk("rst_val", valueToWB, 32'd0);
        chk("rst_res_exmem", result_EXMEM, 32'd0);
        chk("rst_rd_exmem", 32'(rd_EXMEM), 32'd0);
        chk("rst_align", 32'(alignErr), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;

        // ALU op timing
        clr();
        pend_q.push_back(mk(1, 5'd5, 32'h10, 0, 1, 0, 0, 0, 1, 0));
        cycle();
        cycle();
        chk("alu_rd_exmem", 32'(rd_EXMEM), 32'd5);
        chk("alu_res_exmem", result_EXMEM, 32'h10);
        chk("alu_rw_exmem", 32'(regWrite_EXMEM), 32'd1);
        cycle();
        chk("alu_rw_memwb", 32'(regWrite_MEMWB), 32'd1);
        chk("alu_val", valueToWB, 32'h10);
        repeat (3) cycle();

        // Load, ack on the third request cycle
        clr();
        pend_q.push_back(mk(1, 5'd3, 32'h100, 0, 1, 1, 0, 1, 3,
                            32'hDEADBEEF));
        repeat (8) cycle();
        chk("ld_req_cyc", n_req, 3);
        chk("ld_stall_cyc", n_stall, 2);
        chk("ld_wb_cnt", n_wb, 1);

        // Store
        clr();
        pend_q.push_back(mk(1, 5'd9, 32'h204, 32'h55, 1, 0, 1, 0, 2, 0));
        repeat (8) cycle();
        chk("st_req_cyc", n_req, 2);
        chk("st_stall_cyc", n_stall, 1);
        chk("st_wb_cnt", n_wb, 0);

        // Misaligned load
        clr();
        pend_q.push_back(mk(1, 5'd7, 32'h102, 0, 1, 1, 0, 1, 1, 32'h1234));
        repeat (6) cycle();
        chk("mis_req_cyc", n_req, 0);
        chk("mis_align_cnt", n_align, 1);
        chk("mis_wb_cnt", n_wb, 0);

        // Timeout, then a following ALU op is accepted
        clr();
        pend_q.push_back(mk(1, 5'd4, 32'h300, 0, 1, 1, 0, 1, 99, 32'h9));
        pend_q.push_back(mk(1, 5'd6, 32'h77, 0, 1, 0, 0, 0, 1, 0));
        repeat (12) cycle();
        chk("to_stall_cyc", n_stall, TO);
        chk("to_req_cyc", n_req, TO);
        chk("to_pulse_cnt", n_to, 1);
        chk("to_next_wb", n_wb, 1);

        // Reset in the middle of an access
        clr();
        pend_q.push_back(mk(1, 5'd8, 32'h400, 0, 1, 1, 0, 1, 99, 32'h5));
        repeat (3) cycle();
        chk("pre_rst_req", 32'(memReq), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(memReq), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_rw", 32'(regWrite_MEMWB), 32'd0);
        acc_q.delete();
        wb_q.delete();
        pend_q.delete();
        have_cur  = 1'b0;
        cur_ex    = bubble();
        drive_ex(cur_ex);
        ex_loaded = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        pend_q.push_back(mk(1, 5'd10, 32'h500, 0, 1, 1, 0, 1, 2,
                            32'hCAFEF00D));
        repeat (8) cycle();
        chk("postrst_wb", n_wb, 1);
        chk("postrst_req", n_req, 2);

        // Random op stream
        clr();
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 3);
            if (k == 3) begin
                o = bubble();
            end else begin
                o = mk(1, 5'($urandom_range(0, 31)), $urandom, $urandom,
                       1'($urandom_range(0, 3) != 0), 0, 0, 0,
                       $urandom_range(1, 6), $urandom);
                if (k == 1) begin
                    o.memRead  = 1'b1;
                    o.memToReg = 1'($urandom_range(0, 3) != 0);
                end
                if (k == 2) o.memWrite = 1'b1;
                if (k != 0 && $urandom_range(0, 5) != 0)
                    o.result[1:0] = 2'b00;
            end
            pend_q.push_back(o);
        end
        budget = 0;
        while (pend_q.size() != 0 && budget < 20000) begin
            cycle();
            budget++;
        end
        chk("rand_budget", 32'(pend_q.size()), 32'd0);
        repeat (12) cycle();
        chk("rand_wb_left", 32'(wb_q.size()), 32'd0);
        chk("rand_acc_left", 32'(acc_q.size()), 32'd0);
        chk("rand_align_cnt", n_align, exp_align);
        chk("rand_to_cnt", n_to, exp_to);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk in 1, single clock, all state on rising edge; rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have EX-side inputs: result in 32 (ALU result/address); readData2 in 32 (store data); rd_EX in 5; regWrite_EX, memRead_EX, memWrite_EX, memToReg_EX, valid_EX in 1 each.
REQ-003 SHALL have memory port: memReq out 1; memWe out 1; memAddr out 32; memWdata out 32; memRdata in 32; memAck in 1.
REQ-004 SHALL have forwarding/WB outputs: result_EXMEM out 32; rd_EXMEM out 5; regWrite_EXMEM out 1; rd_MEMWB out 5; regWrite_MEMWB out 1; valueToWB out 32.
REQ-005 SHALL have status outputs: stall out 1 (freeze upstream); alignErr out 1; timeout out 1.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 255, meaning: max cycles waiting for memAck.

Function
REQ-007 SHALL hold an EX/MEM register (result, readData2, rd, regWrite, memRead, memWrite, memToReg, valid), loaded every edge when stall=0, held when stall=1.
REQ-008 SHALL force captured regWrite to 0 when rd_EX=0 or valid_EX=0.
REQ-009 SHALL drive result_EXMEM, rd_EXMEM, regWrite_EXMEM directly from the EX/MEM register.
REQ-010 SHALL use FSM states IDLE, ACCESS, DONE.
REQ-011 IDLE->ACCESS on the edge capturing a valid, word-aligned memRead or memWrite op (result[1:0]=0).
REQ-012 ACCESS->IDLE on an edge with memAck=1 and no new mem op captured; ACCESS->ACCESS if a new aligned mem op is captured on that same edge.
REQ-013 ACCESS->DONE when the wait counter reaches TIMEOUT_CYC without memAck; DONE->IDLE next edge.
REQ-014 memReq=1 only in ACCESS; memWe=memWrite of EX/MEM; memAddr={result_EXMEM[31:2],2'b00}; memWdata=EX/MEM store data.
REQ-015 stall SHALL be 1 iff state=ACCESS and memAck=0 (combinational); one-cycle ack latency gives 0 extra stall cycles.
REQ-016 Wait counter: 8+ bits, cleared on entry to ACCESS, incremented each ACCESS cycle with memAck=0.
REQ-017 MEM/WB register SHALL load every edge: rd_MEMWB<=rd_EXMEM; regWrite_MEMWB<=regWrite_EXMEM when the EX/MEM op completes this cycle, else 0 (bubble).
REQ-018 EX/MEM op completes when: non-memory op (1 cycle); memAck=1 in ACCESS; never on misaligned or timed-out op.
REQ-019 valueToWB<=memRdata if memToReg and memRead and ack, else result_EXMEM.
REQ-020 Store ops SHALL always load regWrite_MEMWB=0.
REQ-021 Misaligned mem op: no memReq, alignErr 1-cycle pulse on the cycle after capture, MEM/WB bubble.
REQ-022 Timeout: timeout 1-cycle pulse in DONE, MEM/WB bubble, stall released in DONE.
REQ-023 memAck outside ACCESS SHALL be ignored.

Reset
REQ-024 rst_n=0 SHALL immediately clear all registers, outputs to 0, state IDLE, memReq=0, stall=0.
REQ-025 Reset mid-ACCESS SHALL abort the access with no MEM/WB writeback; first op after release accepted normally.

Verification
REQ-026 ALU op result=0x10, rd_EX=5, regWrite=1 -> next edge rd_EXMEM=5, result_EXMEM=0x10; following edge regWrite_MEMWB=1, valueToWB=0x10.
REQ-027 Load result=0x100, memAck after 3 cycles with memRdata=0xDEADBEEF -> memReq high 3 cycles, stall high 2 then low; valueToWB=0xDEADBEEF, regWrite_MEMWB=1 once.
REQ-028 Store result=0x204, readData2=0x55 -> memWe=1, memAddr=0x204, memWdata=0x55; regWrite_MEMWB stays 0.
REQ-029 Load result=0x102 -> memReq never asserts, alignErr one pulse, regWrite_MEMWB=0.
REQ-030 Load with memAck held 0, TIMEOUT_CYC=4 -> stall high 4 cycles, timeout one pulse, next op accepted; and rst_n=0 mid-ACCESS -> memReq, stall 0 immediately.
